// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: pixel prescaler, horizontal/vertical counters and
// registered sync/video decode. A stop request takes effect only at the end of a frame.
module vga_timing_controller #(
   parameter int TICKS_PER_PIXEL = 2,
   parameter int H_VISIBLE       = 640,
   parameter int H_FP            = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BP            = 48,
   parameter int V_VISIBLE       = 480,
   parameter int V_FP            = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BP            = 33
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic       running,
   output logic       pixel_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int PW      = (TICKS_PER_PIXEL > 1) ? $clog2(TICKS_PER_PIXEL) : 1;

   localparam logic [PW-1:0] PS_LAST  = PW'(TICKS_PER_PIXEL - 1);
   localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]    H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0]    V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0]    HS_FIRST = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0]    HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0]    VS_FIRST = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0]    VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [PW-1:0]   prescaler, prescaler_n;
   logic [9:0]      x_n, y_n;
   logic            tick, line_end, frame_end;
   logic            run_n, tick_n, fs_n, hsync_n, vsync_n, video_n;

   // Next-state and next-counter values; every output register is loaded
   // from these so the decode always matches the pixel being presented.
   always_comb begin
      state_n     = state;
      prescaler_n = '0;
      x_n         = '0;
      y_n         = '0;
      tick        = (state != IDLE) && (prescaler == PS_LAST);
      line_end    = tick && (pixel_x == H_LAST);
      frame_end   = line_end && (pixel_y == V_LAST);

      case (state)
         IDLE:     if (enable) state_n = RUN;
         RUN:      if (!enable) state_n = frame_end ? IDLE : STOPPING;
         STOPPING: begin
            if (enable)         state_n = RUN;
            else if (frame_end) state_n = IDLE;
         end
         default:  state_n = IDLE;
      endcase

      run_n = (state_n != IDLE);

      // Counters only advance while staying active; entering or leaving IDLE loads (0,0).
      if (run_n && (state != IDLE)) begin
         prescaler_n = (prescaler == PS_LAST) ? '0 : prescaler + PW'(1);
         x_n         = pixel_x;
         y_n         = pixel_y;
         if (tick) begin
            if (line_end) begin
               x_n = '0;
               y_n = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
            end else begin
               x_n = pixel_x + 10'd1;
            end
         end
      end

      fs_n    = run_n && ((state == IDLE) || frame_end);
      tick_n  = run_n && (prescaler_n == PS_LAST);
      hsync_n = !(run_n && (x_n >= HS_FIRST) && (x_n <= HS_LAST));
      vsync_n = !(run_n && (y_n >= VS_FIRST) && (y_n <= VS_LAST));
      video_n = run_n && (x_n < H_VIS) && (y_n < V_VIS);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         prescaler   <= '0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         running     <= 1'b0;
         pixel_tick  <= 1'b0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         video_on    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_n;
         prescaler   <= prescaler_n;
         pixel_x     <= x_n;
         pixel_y     <= y_n;
         running     <= run_n;
         pixel_tick  <= tick_n;
         hsync       <= hsync_n;
         vsync       <= vsync_n;
         video_on    <= video_n;
         frame_start <= fs_n;
      end
   end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller on a reduced raster (15x10 pixels,
// 2 clk/pixel: 30 clk per line, 300 clk per frame) so whole frames fit in a short run.
module tb_vga_timing_controller;

   // Reduced timing: hsync low at x 10..12, vsync low at y 7..8, visible 8x6.
   localparam int T  = 2;
   localparam int HV = 8, HF = 2, HS = 3, HB = 2;
   localparam int VV = 6, VF = 1, VS = 2, VB = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       running, pixel_tick, hsync, vsync, video_on, frame_start;
   logic [9:0] pixel_x, pixel_y;

   int checks = 0;
   int errors = 0;

   int cyc, fs_count, last_fs, fs_period, vid_cnt, vid_at_fs, vid_frame;
   int hs_run, hs_last, hs_start_x, vs_run, vs_last, vs_start_y, vs_start_x;
   int idle_cnt, idle_bad, tick_cnt, fs_before, n;
   int prev_x, prev_y, prev_tick;
   logic prev_hs, prev_vs;

   vga_timing_controller #(
      .TICKS_PER_PIXEL(T),
      .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .running(running),
      .pixel_tick(pixel_tick),
      .pixel_x(pixel_x),
      .pixel_y(pixel_y),
      .hsync(hsync),
      .vsync(vsync),
      .video_on(video_on),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_running"}, int'(running), 0);
      check({tag, "_tick"}, int'(pixel_tick), 0);
      check({tag, "_x"}, int'(pixel_x), 0);
      check({tag, "_y"}, int'(pixel_y), 0);
      check({tag, "_hsync"}, int'(hsync), 1);
      check({tag, "_vsync"}, int'(vsync), 1);
      check({tag, "_video"}, int'(video_on), 0);
      check({tag, "_fs"}, int'(frame_start), 0);
   endtask

   // One sample per clk on the falling edge, accumulating raster statistics.
   task automatic step();
      prev_x    = int'(pixel_x);
      prev_y    = int'(pixel_y);
      prev_tick = int'(pixel_tick);
      @(negedge clk);
      cyc++;
      if (frame_start) begin
         fs_count++;
         if (fs_count > 1) fs_period = cyc - last_fs;
         last_fs   = cyc;
         vid_frame = vid_cnt - vid_at_fs;
         vid_at_fs = vid_cnt;
      end
      if (video_on) vid_cnt++;
      if (!hsync) begin
         if (prev_hs) begin
            hs_start_x = int'(pixel_x);
            hs_run     = 0;
         end
         hs_run++;
      end else if (!prev_hs) hs_last = hs_run;
      if (!vsync) begin
         if (prev_vs) begin
            vs_start_y = int'(pixel_y);
            vs_start_x = int'(pixel_x);
            vs_run     = 0;
         end
         vs_run++;
      end else if (!prev_vs) vs_last = vs_run;
      if (!running) idle_cnt++;
      if (pixel_tick) tick_cnt++;
      prev_hs = hsync;
      prev_vs = vsync;
   endtask

   task automatic wait_y(input int y, input string tag);
      int k;
      k = 0;
      while (int'(pixel_y) != y && k < 400) begin
         step();
         k++;
      end
      check(tag, int'(pixel_y), y);
   endtask

   initial begin
      cyc = 0; fs_count = 0; last_fs = 0; fs_period = 0;
      vid_cnt = 0; vid_at_fs = 0; vid_frame = 0;
      hs_run = 0; hs_last = 0; hs_start_x = -1;
      vs_run = 0; vs_last = 0; vs_start_y = -1; vs_start_x = -1;
      idle_cnt = 0; idle_bad = 0; tick_cnt = 0; fs_before = 0; n = 0;
      prev_x = 0; prev_y = 0; prev_tick = 0;
      prev_hs = 1'b1; prev_vs = 1'b1;

      // Reset takes effect before any clock edge.
      #1 reset = 1'b1;
      #1 check_reset_values("por");
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Idle with enable low for 100 clk.
      for (int i = 0; i < 100; i++) begin
         step();
         if (running || pixel_x != 0 || pixel_y != 0 || !hsync || !vsync || video_on || frame_start)
            idle_bad++;
      end
      check("idle_bad", idle_bad, 0);
      check("idle_ticks", tick_cnt, 0);

      // Start: first RUN sample presents (0,0) with frame_start.
      cyc = -1; fs_count = 0; vid_cnt = 0; vid_at_fs = 0;
      enable = 1'b1;
      step();
      check("start_running", int'(running), 1);
      check("start_fs", int'(frame_start), 1);
      check("start_x", int'(pixel_x), 0);
      check("start_y", int'(pixel_y), 0);
      check("start_tick", int'(pixel_tick), 0);
      check("start_video", int'(video_on), 1);
      check("start_hsync", int'(hsync), 1);
      check("start_vsync", int'(vsync), 1);
      step();
      check("c1_tick", int'(pixel_tick), 1);
      check("c1_fs", int'(frame_start), 0);
      check("c1_x", int'(pixel_x), 0);
      step();
      check("c2_x", int'(pixel_x), 1);
      check("c2_tick", int'(pixel_tick), 0);
      repeat (27) step();
      check("c29_x", int'(pixel_x), 14);
      check("c29_y", int'(pixel_y), 0);
      check("c29_tick", int'(pixel_tick), 1);
      step();
      check("c30_x", int'(pixel_x), 0);
      check("c30_y", int'(pixel_y), 1);

      // Two full frames of statistics.
      repeat (575) step();
      check("fs_count", fs_count, 3);
      check("fs_period", fs_period, 300);
      check("video_per_frame", vid_frame, 96);
      check("hs_low_len", hs_last, 6);
      check("hs_start_x", hs_start_x, 10);
      check("vs_low_len", vs_last, 60);
      check("vs_start_y", vs_start_y, 7);
      check("vs_start_x", vs_start_x, 0);

      // Stop request mid-frame: the frame completes, then IDLE.
      wait_y(3, "stop_wait_y3");
      enable = 1'b0;
      fs_before = fs_count;
      n = 0;
      while (running && n < 400) begin
         step();
         n++;
      end
      check("stop_running", int'(running), 0);
      check("stop_at_frame_len", cyc - last_fs, 300);
      check("stop_prev_x", prev_x, 14);
      check("stop_prev_y", prev_y, 9);
      check("stop_prev_tick", prev_tick, 1);
      check("stop_x", int'(pixel_x), 0);
      check("stop_y", int'(pixel_y), 0);
      check("stop_fs", int'(frame_start), 0);
      check("stop_no_new_fs", fs_count, fs_before);
      repeat (5) step();
      check("stopped_running", int'(running), 0);
      check("stopped_hsync", int'(hsync), 1);

      // Stop then re-request mid-frame: no gap, next frame on time.
      enable = 1'b1;
      step();
      check("restart_fs", int'(frame_start), 1);
      wait_y(3, "resume_wait_y3");
      enable = 1'b0;
      wait_y(6, "resume_wait_y6");
      enable = 1'b1;
      idle_cnt = 0;
      n = 0;
      do begin
         step();
         n++;
      end while (!frame_start && n < 400);
      check("resume_fs", int'(frame_start), 1);
      check("resume_period", fs_period, 300);
      check("resume_no_idle", idle_cnt, 0);

      // Enable returns on the very frame-end tick while stopping.
      enable = 1'b0;
      n = 0;
      while (!(pixel_x == 10'd14 && pixel_y == 10'd9 && pixel_tick) && n < 400) begin
         step();
         n++;
      end
      check("edge_at_frame_end", int'(pixel_tick), 1);
      enable = 1'b1;
      step();
      check("edge_running", int'(running), 1);
      check("edge_fs", int'(frame_start), 1);
      check("edge_x", int'(pixel_x), 0);
      check("edge_y", int'(pixel_y), 0);
      check("edge_period", fs_period, 300);

      // Asynchronous reset in the visible area, then restart.
      wait_y(3, "rst_wait_y3");
      n = 0;
      while (pixel_x != 10'd4 && n < 40) begin
         step();
         n++;
      end
      check("rst_pre_x", int'(pixel_x), 4);
      check("rst_pre_video", int'(video_on), 1);
      reset = 1'b1;
      #1 check_reset_values("async_rst");
      enable = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      repeat (3) step();
      check("post_rst_running", int'(running), 0);
      check("post_rst_x", int'(pixel_x), 0);
      enable = 1'b1;
      step();
      check("rerun_running", int'(running), 1);
      check("rerun_fs", int'(frame_start), 1);
      check("rerun_x", int'(pixel_x), 0);
      check("rerun_y", int'(pixel_y), 0);
      check("rerun_video", int'(video_on), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
